regfile_writeback: RTL and testbench

//   Writeback stage driving the register-file write port (we/waddr/wd) read by the decode stage.

---
 rtl/regfile_writeback_pkg.sv | 49 ++++
 rtl/regfile_writeback_load_align.sv | 43 ++++
 rtl/regfile_writeback.sv | 152 +++++++++++++++
 tb/tb_regfile_writeback.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_writeback_pkg.sv
// Shared types for the writeback stage: result-source select, load func3
// encodings and the buffered entry layout.
package rv_wb_pkg;

  // Result source selected by the writeback mux.
  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_IMM  = 2'b11
  } wb_sel_e;

  // Load width/sign encodings (RV32I func3).
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // One buffered result. Non-load sources are resolved to their final value
  // at push time; loads keep the raw memory word and are aligned at pop.
  typedef struct packed {
    logic [4:0]  rd;
    wb_sel_e     wb_sel;
    logic [2:0]  func3;
    logic [1:0]  byte_off;
    logic [31:0] data;
  } wb_entry_t;

  // Pick the 32-bit payload stored for an incoming result.
  function automatic logic [31:0] select_source(
    input wb_sel_e     sel,
    input logic [31:0] alu_result,
    input logic [31:0] mem_rdata,
    input logic [31:0] pc,
    input logic [31:0] imm
  );
    logic [31:0] value;
    case (sel)
      WB_ALU:  value = alu_result;
      WB_LOAD: value = mem_rdata;
      WB_PC4:  value = pc + 32'd4;
      WB_IMM:  value = imm;
      default: value = alu_result;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/regfile_writeback_load_align.sv
// Load data aligner: shifts the raw memory word by the byte offset and
// sign/zero-extends according to func3. Flags misaligned or unsupported loads.
module wb_load_align
  import rv_wb_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  func3,
  input  logic [1:0]  byte_off,
  output logic [31:0] data,
  output logic        misalign
);

  logic [31:0] shifted;

  // Extract and extend the addressed byte/half/word; zero data when flagged.
  always_comb begin
    shifted  = rdata >> {byte_off, 3'b000};
    data     = '0;
    misalign = 1'b0;
    case (func3)
      F3_LB:  data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU: data = {24'b0, shifted[7:0]};
      F3_LH: begin
        data     = {{16{shifted[15]}}, shifted[15:0]};
        misalign = (byte_off == 2'd3);
      end
      F3_LHU: begin
        data     = {16'b0, shifted[15:0]};
        misalign = (byte_off == 2'd3);
      end
      F3_LW: begin
        data     = rdata;
        misalign = (byte_off != 2'd0);
      end
      // Reserved encodings are reported the same way as a misaligned access.
      default: misalign = 1'b1;
    endcase
    if (misalign) begin
      data = '0;
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback stage: buffers completed results in a small circular FIFO and
// retires one register-file write per cycle, with a retired-instruction count.
module regfile_writeback
  import rv_wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             hold,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd,
  input  logic [1:0]       in_wb_sel,
  input  logic [2:0]       in_func3,
  input  logic [1:0]       in_byte_off,
  input  logic [31:0]      in_alu_result,
  input  logic [31:0]      in_mem_rdata,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_imm,
  output logic             we,
  output logic [4:0]       waddr,
  output logic [31:0]      wd,
  output logic             load_misalign,
  output logic [CNT_W-1:0] retired
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_BITS = PTR_W + 1;
  localparam logic [CNT_BITS-1:0] FULL = CNT_BITS'(DEPTH);

  logic [PTR_W-1:0]    rd_ptr_reg;
  logic [PTR_W-1:0]    wr_ptr_reg;
  logic [CNT_BITS-1:0] count_reg;

  wb_entry_t           slot_mem [DEPTH];
  wb_entry_t           new_entry;
  wb_entry_t           head;
  logic [DEPTH-1:0]    slot_we;

  logic                push;
  logic                pop;

  logic [31:0]         align_data;
  logic                align_mis;
  logic                head_is_load;
  logic                head_mis;
  logic [31:0]         head_wd;

  // Full means no push at all, even if the head leaves in the same cycle.
  assign in_ready = (count_reg != FULL);
  assign push     = in_valid && in_ready && !flush;
  assign pop      = (count_reg != '0) && !hold && !flush;

  // Assemble the entry to store; non-load sources are resolved here.
  always_comb begin
    new_entry          = '0;
    new_entry.rd       = in_rd;
    new_entry.wb_sel   = wb_sel_e'(in_wb_sel);
    new_entry.func3    = in_func3;
    new_entry.byte_off = in_byte_off;
    new_entry.data     = select_source(wb_sel_e'(in_wb_sel), in_alu_result,
                                       in_mem_rdata, in_pc, in_imm);
  end

  // Per-slot write strobes decoded from the tail pointer.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot_we
      assign slot_we[gi] = push && (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  // Buffer storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_we[i]) begin
        slot_mem[i] <= new_entry;
      end
    end
  end

  assign head = slot_mem[rd_ptr_reg];

  wb_load_align u_align (
    .rdata    (head.data),
    .func3    (head.func3),
    .byte_off (head.byte_off),
    .data     (align_data),
    .misalign (align_mis)
  );

  assign head_is_load = (head.wb_sel == WB_LOAD);
  assign head_mis     = head_is_load && align_mis;
  assign head_wd      = head_is_load ? align_data : head.data;

  // Pointer and occupancy tracking; flush empties the buffer outright.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_BITS'(1);
        2'b01:   count_reg <= count_reg - CNT_BITS'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Register-file write port: loaded from the head on a pop, idle otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we            <= 1'b0;
      waddr         <= '0;
      wd            <= '0;
      load_misalign <= 1'b0;
    end else if (pop) begin
      // x0 and faulting loads still update address/data but never write.
      we            <= (head.rd != 5'd0) && !head_mis;
      waddr         <= head.rd;
      wd            <= head_wd;
      load_misalign <= head_mis;
    end else begin
      we            <= 1'b0;
      load_misalign <= 1'b0;
    end
  end

  // Retired count includes x0 and misaligned pops; wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired <= '0;
    end else if (pop) begin
      retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed vector table, hand-written multi-cycle
// sequences and random traffic, all checked against a queue-based model.
module tb_regfile_writeback;
  import rv_wb_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             hold;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_rd;
  logic [1:0]       in_wb_sel;
  logic [2:0]       in_func3;
  logic [1:0]       in_byte_off;
  logic [31:0]      in_alu_result;
  logic [31:0]      in_mem_rdata;
  logic [31:0]      in_pc;
  logic [31:0]      in_imm;
  logic             we;
  logic [4:0]       waddr;
  logic [31:0]      wd;
  logic             load_misalign;
  logic [CNT_W-1:0] retired;

  regfile_writeback #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
    .in_wb_sel(in_wb_sel), .in_func3(in_func3), .in_byte_off(in_byte_off),
    .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
    .in_pc(in_pc), .in_imm(in_imm), .we(we), .waddr(waddr), .wd(wd),
    .load_misalign(load_misalign), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc;
    logic [31:0] imm;
  } in_t;

  typedef struct {
    logic [4:0]  rd;
    bit          we;
    bit          mis;
    logic [31:0] wd;
  } res_t;

  typedef struct {
    in_t         x;
    bit          we;
    bit          mis;
    logic [31:0] wd;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference model state
  res_t        mq[$];
  bit          e_we, e_mis, wd_known;
  logic [4:0]  e_waddr;
  logic [31:0] e_wd;
  logic [31:0] e_ret;
  in_t         cur;
  bit          cur_valid;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic in_t mk(input logic [4:0] rd, input logic [1:0] sel,
                             input logic [2:0] f3, input logic [1:0] off,
                             input logic [31:0] alu, input logic [31:0] rdata,
                             input logic [31:0] pc, input logic [31:0] imm);
    in_t x;
    x.rd = rd; x.sel = sel; x.f3 = f3; x.off = off;
    x.alu = alu; x.rdata = rdata; x.pc = pc; x.imm = imm;
    return x;
  endfunction

  // Expected result of one entry, from the writeback rules in arithmetic form.
  function automatic res_t ref_result(input in_t x);
    res_t r;
    logic [31:0] v, sh;
    bit m;
    m = 0;
    v = 0;
    case (x.sel)
      2'd0: v = x.alu;
      2'd2: v = x.pc + 32'd4;
      2'd3: v = x.imm;
      default: begin
        sh = x.rdata >> (8 * x.off);
        case (x.f3)
          3'd0: begin v = sh % 256;   if (v >= 128)   v = v - 256; end
          3'd4: v = sh % 256;
          3'd1: begin v = sh % 65536; if (v >= 32768) v = v - 65536; m = (x.off == 3); end
          3'd5: begin v = sh % 65536; m = (x.off == 3); end
          3'd2: begin v = x.rdata;    m = (x.off != 0); end
          default: m = 1;
        endcase
      end
    endcase
    r.rd  = x.rd;
    r.mis = m;
    r.we  = !m && (x.rd != 0);
    r.wd  = v;
    return r;
  endfunction

  task automatic drive(input in_t x, input bit v);
    cur           = x;
    cur_valid     = v;
    in_valid      = v;
    in_rd         = x.rd;
    in_wb_sel     = x.sel;
    in_func3      = x.f3;
    in_byte_off   = x.off;
    in_alu_result = x.alu;
    in_mem_rdata  = x.rdata;
    in_pc         = x.pc;
    in_imm        = x.imm;
  endtask

  task automatic model_reset();
    mq.delete();
    e_we = 0; e_mis = 0; e_waddr = 0; e_wd = 0; e_ret = 0; wd_known = 1;
  endtask

  // One clock: check ready, advance model across the edge, check outputs.
  task automatic step();
    res_t h;
    int   sz;
    chk("in_ready", {31'b0, in_ready}, (mq.size() < DEPTH) ? 32'd1 : 32'd0);
    @(posedge clk);
    sz = mq.size();
    if (flush) begin
      mq.delete();
      e_we = 0; e_mis = 0;
    end else begin
      if (sz > 0 && !hold) begin
        h = mq.pop_front();
        e_we = h.we; e_mis = h.mis; e_waddr = h.rd;
        e_wd = h.wd; wd_known = !h.mis;
        e_ret = e_ret + 1;
        $display("txn retire: rd=%0d we=%0b wd=%h misalign=%0b", h.rd, h.we, h.wd, h.mis);
      end else begin
        e_we = 0; e_mis = 0;
      end
      if (cur_valid && sz < DEPTH) begin
        mq.push_back(ref_result(cur));
      end
    end
    #1;
    chk("we", {31'b0, we}, {31'b0, e_we});
    chk("load_misalign", {31'b0, load_misalign}, {31'b0, e_mis});
    chk("retired", retired, e_ret);
    chk("waddr", {27'b0, waddr}, {27'b0, e_waddr});
    if (wd_known) chk("wd", wd, e_wd);
  endtask

  vec_t vecs[13];
  in_t  idle, a, b, c;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0; flush = 1'b0; hold = 1'b0;
    drive(idle, 0);
    model_reset();

    // Power-on reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_we", {31'b0, we}, 32'd0);
    chk("rst_waddr", {27'b0, waddr}, 32'd0);
    chk("rst_wd", wd, 32'd0);
    chk("rst_mis", {31'b0, load_misalign}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    reset = 1'b1;

    // Directed vectors: each pushed into an empty buffer, written next edge.
    vecs[0]  = '{mk(5,  0, 0, 0, 32'h1234_5678, 0, 0, 0), 1, 0, 32'h1234_5678};
    vecs[1]  = '{mk(7,  1, 0, 1, 0, 32'h80FF_7F01, 0, 0), 1, 0, 32'h0000_007F};
    vecs[2]  = '{mk(7,  1, 0, 3, 0, 32'h80FF_7F01, 0, 0), 1, 0, 32'hFFFF_FF80};
    vecs[3]  = '{mk(8,  1, 5, 2, 0, 32'h80FF_7F01, 0, 0), 1, 0, 32'h0000_80FF};
    vecs[4]  = '{mk(9,  1, 2, 2, 0, 32'h80FF_7F01, 0, 0), 0, 1, 32'h0};
    vecs[5]  = '{mk(0,  0, 0, 0, 32'hDEAD_BEEF, 0, 0, 0), 0, 0, 32'hDEAD_BEEF};
    vecs[6]  = '{mk(3,  2, 0, 0, 0, 0, 32'hFFFF_FFFC, 0), 1, 0, 32'h0};
    vecs[7]  = '{mk(31, 3, 0, 0, 0, 0, 0, 32'hABCD_E000), 1, 0, 32'hABCD_E000};
    vecs[8]  = '{mk(4,  1, 1, 1, 0, 32'h80FF_7F01, 0, 0), 1, 0, 32'hFFFF_FF7F};
    vecs[9]  = '{mk(4,  1, 4, 3, 0, 32'h80FF_7F01, 0, 0), 1, 0, 32'h0000_0080};
    vecs[10] = '{mk(6,  1, 3, 0, 0, 32'h80FF_7F01, 0, 0), 0, 1, 32'h0};
    vecs[11] = '{mk(6,  1, 5, 3, 0, 32'h80FF_7F01, 0, 0), 0, 1, 32'h0};
    vecs[12] = '{mk(10, 1, 2, 0, 0, 32'h80FF_7F01, 0, 0), 1, 0, 32'h80FF_7F01};

    @(posedge clk); #1;
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].x, 1);
      step();
      drive(idle, 0);
      step();
      chk($sformatf("vec%0d_we", i), {31'b0, we}, {31'b0, vecs[i].we});
      chk($sformatf("vec%0d_mis", i), {31'b0, load_misalign}, {31'b0, vecs[i].mis});
      chk($sformatf("vec%0d_waddr", i), {27'b0, waddr}, {27'b0, vecs[i].x.rd});
      if (!vecs[i].mis) chk($sformatf("vec%0d_wd", i), wd, vecs[i].wd);
    end

    // Hold with three back-to-back offers: third is refused, then in-order drain.
    a = mk(11, 0, 0, 0, 32'hAAAA_0001, 0, 0, 0);
    b = mk(12, 0, 0, 0, 32'hBBBB_0002, 0, 0, 0);
    c = mk(13, 0, 0, 0, 32'hCCCC_0003, 0, 0, 0);
    hold = 1'b1;
    drive(a, 1); step();
    drive(b, 1); step();
    drive(c, 1);
    chk("hold_full_ready", {31'b0, in_ready}, 32'd0);
    step();
    drive(idle, 0); hold = 1'b0;
    step();
    chk("hold_first_we", {31'b0, we}, 32'd1);
    chk("hold_first_waddr", {27'b0, waddr}, 32'd11);
    step();
    chk("hold_second_waddr", {27'b0, waddr}, 32'd12);
    chk("hold_second_wd", wd, 32'hBBBB_0002);
    step();
    chk("hold_drained_we", {31'b0, we}, 32'd0);

    // Flush with a full buffer and a concurrent push: nothing is written after.
    hold = 1'b1;
    drive(a, 1); step();
    drive(b, 1); step();
    drive(c, 1); hold = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; drive(idle, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("flush_we_%0d", i), {31'b0, we}, 32'd0);
    end

    // Asynchronous reset mid-stream with two entries buffered.
    hold = 1'b1;
    drive(a, 1); step();
    drive(b, 1); step();
    drive(idle, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_we", {31'b0, we}, 32'd0);
    chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    chk("mid_rst_retired", retired, 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1; hold = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      in_t x;
      x = mk(5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
             3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
             $urandom, $urandom, $urandom, $urandom);
      drive(x, ($urandom_range(0, 3) != 0));
      hold  = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 31) == 0);
      step();
    end
    hold = 1'b0; flush = 1'b0; drive(idle, 0);
    for (int i = 0; i < 4; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
